// File: rtl/dma_pkg.sv
// Shared constants and types for the four-channel DMA scheduler:
// register map, control bit positions and scheduler states.
package dma_pkg;

    localparam int NCH = 4;

    localparam logic [3:0] IDX_SADD_LO  = 4'd0;
    localparam logic [3:0] IDX_SADD_HI  = 4'd1;
    localparam logic [3:0] IDX_SINC_LO  = 4'd2;
    localparam logic [3:0] IDX_SINC_HI  = 4'd3;
    localparam logic [3:0] IDX_DADD_LO  = 4'd4;
    localparam logic [3:0] IDX_DADD_HI  = 4'd5;
    localparam logic [3:0] IDX_DINC_LO  = 4'd6;
    localparam logic [3:0] IDX_DINC_HI  = 4'd7;
    localparam logic [3:0] IDX_COUNT_LO = 4'd8;
    localparam logic [3:0] IDX_COUNT_HI = 4'd9;
    localparam logic [3:0] IDX_CTRL     = 4'd10;
    localparam logic [3:0] IDX_DCLR     = 4'd11;

    localparam int CTL_START  = 0;
    localparam int CTL_IRQEN  = 1;
    localparam int CTL_CANCEL = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb4.sv
// Combinational four-way round-robin arbiter: the search starts at the
// channel after last_grant and wraps modulo 4.
module rr_arb4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant,
    output logic       valid
);

    logic [7:0] dbl_s;
    logic [2:0] base_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // rotate so the highest-priority channel sits in bit 0, then take the lowest set bit
    always_comb begin
        dbl_s  = {req, req};
        base_s = {1'b0, last_grant} + 3'd1;
        rot_s  = dbl_s[base_s +: 4];
        off_s  = 2'd0;
        valid  = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s = 2'd0;
                valid = 1'b0;
            end
        endcase
        grant = last_grant + 2'd1 + off_s;
    end

endmodule

// File: rtl/dma_sched.sv
// Four-channel DMA scheduler: CPU-programmed channel registers, round-robin
// grant, and a start/done handshake with an external copy engine.
module dma_sched import dma_pkg::*; #(
    parameter int NCH = dma_pkg::NCH
) (
    input  logic           PHI2,
    input  logic           rst,
    input  logic           reg_we,
    input  logic [5:0]     reg_addr,
    input  logic [7:0]     reg_wdata,
    output logic [15:0]    eng_sadd,
    output logic [15:0]    eng_sinc,
    output logic [15:0]    eng_dadd,
    output logic [15:0]    eng_dinc,
    output logic [15:0]    eng_count,
    output logic           eng_start,
    input  logic           eng_done,
    output logic [1:0]     active_ch,
    output logic [NCH-1:0] ch_pend,
    output logic [NCH-1:0] ch_done,
    output logic           irq
);

    logic [1:0]     ch_sel_s;
    logic [3:0]     idx_s;
    logic [15:0]    sadd_r [NCH];
    logic [15:0]    sinc_r [NCH];
    logic [15:0]    dadd_r [NCH];
    logic [15:0]    dinc_r [NCH];
    logic [15:0]    count_r [NCH];
    logic [NCH-1:0] pend_r, done_r, irqen_r;
    logic [NCH-1:0] wr_hit_s, start_s, cancel_s, dclr_s, cmp_s;
    state_e         state_r, state_nxt_s;
    logic [1:0]     last_grant_r, active_ch_r, arb_grant_s, granted_ch_s;
    logic           arb_valid_s, granted_vld_s;
    logic           load_s, zero_cmp_s, run_cmp_s;
    logic [15:0]    eng_sadd_r, eng_sinc_r, eng_dadd_r, eng_dinc_r, eng_count_r;
    logic           eng_start_r;

    assign ch_sel_s = reg_addr[5:4];
    assign idx_s    = reg_addr[3:0];

    rr_arb4 u_arb (
        .req        (pend_r),
        .last_grant (last_grant_r),
        .grant      (arb_grant_s),
        .valid      (arb_valid_s)
    );

    // channel holding the grant, or receiving it on this edge; cancels to it are ignored
    always_comb begin
        granted_vld_s = 1'b0;
        granted_ch_s  = arb_grant_s;
        if (state_r != ST_IDLE) begin
            granted_vld_s = 1'b1;
            granted_ch_s  = active_ch_r;
        end else begin
            granted_vld_s = arb_valid_s;
            granted_ch_s  = arb_grant_s;
        end
    end

    // per-channel write, cancel and completion strobes
    always_comb begin
        wr_hit_s = {NCH{1'b0}};
        start_s  = {NCH{1'b0}};
        cancel_s = {NCH{1'b0}};
        dclr_s   = {NCH{1'b0}};
        cmp_s    = {NCH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            wr_hit_s[c] = reg_we && (ch_sel_s == 2'(c));
            start_s[c]  = wr_hit_s[c] && (idx_s == IDX_CTRL) && !pend_r[c] && reg_wdata[CTL_START];
            cancel_s[c] = wr_hit_s[c] && (idx_s == IDX_CTRL) && pend_r[c] && reg_wdata[CTL_CANCEL]
                          && !(granted_vld_s && (granted_ch_s == 2'(c)));
            dclr_s[c]   = wr_hit_s[c] && (idx_s == IDX_DCLR);
            cmp_s[c]    = (zero_cmp_s && (arb_grant_s == 2'(c))) ||
                          (run_cmp_s && (active_ch_r == 2'(c)));
        end
    end

    // channel parameter registers and pend/done/irq-enable flags
    always_ff @(posedge PHI2) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                sadd_r[c]  <= 16'd0;
                sinc_r[c]  <= 16'd0;
                dadd_r[c]  <= 16'd0;
                dinc_r[c]  <= 16'd0;
                count_r[c] <= 16'd0;
            end
            pend_r  <= {NCH{1'b0}};
            done_r  <= {NCH{1'b0}};
            irqen_r <= {NCH{1'b0}};
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (wr_hit_s[c] && !pend_r[c]) begin
                    case (idx_s)
                        IDX_SADD_LO:  sadd_r[c][7:0]   <= reg_wdata;
                        IDX_SADD_HI:  sadd_r[c][15:8]  <= reg_wdata;
                        IDX_SINC_LO:  sinc_r[c][7:0]   <= reg_wdata;
                        IDX_SINC_HI:  sinc_r[c][15:8]  <= reg_wdata;
                        IDX_DADD_LO:  dadd_r[c][7:0]   <= reg_wdata;
                        IDX_DADD_HI:  dadd_r[c][15:8]  <= reg_wdata;
                        IDX_DINC_LO:  dinc_r[c][7:0]   <= reg_wdata;
                        IDX_DINC_HI:  dinc_r[c][15:8]  <= reg_wdata;
                        IDX_COUNT_LO: count_r[c][7:0]  <= reg_wdata;
                        IDX_COUNT_HI: count_r[c][15:8] <= reg_wdata;
                        default: begin
                        end
                    endcase
                end
                if (start_s[c]) begin
                    pend_r[c]  <= 1'b1;
                    irqen_r[c] <= reg_wdata[CTL_IRQEN];
                end
                if (cancel_s[c]) begin
                    pend_r[c] <= 1'b0;
                end
                if (dclr_s[c]) begin
                    done_r[c] <= 1'b0;
                end
                // completion is last so a same-edge done-clear loses
                if (cmp_s[c]) begin
                    pend_r[c] <= 1'b0;
                    done_r[c] <= 1'b1;
                end
            end
        end
    end

    // scheduler state register
    always_ff @(posedge PHI2) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic; a zero-length grant completes straight from IDLE
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        zero_cmp_s  = 1'b0;
        run_cmp_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    if (count_r[arb_grant_s] == 16'd0) begin
                        zero_cmp_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_ISSUE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (eng_done) begin
                    run_cmp_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // engine parameter latch, start pulse, grant bookkeeping
    always_ff @(posedge PHI2) begin
        if (rst) begin
            eng_sadd_r   <= 16'd0;
            eng_sinc_r   <= 16'd0;
            eng_dadd_r   <= 16'd0;
            eng_dinc_r   <= 16'd0;
            eng_count_r  <= 16'd0;
            eng_start_r  <= 1'b0;
            active_ch_r  <= 2'd0;
            last_grant_r <= 2'd3;
        end else begin
            eng_start_r <= (state_r == ST_ISSUE);
            if (load_s) begin
                active_ch_r <= arb_grant_s;
                eng_sadd_r  <= sadd_r[arb_grant_s];
                eng_sinc_r  <= sinc_r[arb_grant_s];
                eng_dadd_r  <= dadd_r[arb_grant_s];
                eng_dinc_r  <= dinc_r[arb_grant_s];
                eng_count_r <= count_r[arb_grant_s];
            end
            if (zero_cmp_s) begin
                last_grant_r <= arb_grant_s;
            end else if (run_cmp_s) begin
                last_grant_r <= active_ch_r;
            end
        end
    end

    assign eng_sadd  = eng_sadd_r;
    assign eng_sinc  = eng_sinc_r;
    assign eng_dadd  = eng_dadd_r;
    assign eng_dinc  = eng_dinc_r;
    assign eng_count = eng_count_r;
    assign eng_start = eng_start_r;
    assign active_ch = active_ch_r;
    assign ch_pend   = pend_r;
    assign ch_done   = done_r;
    assign irq       = |(done_r & irqen_r);

endmodule

// File: tb/tb_dma_sched.sv
// Self-checking bench for dma_sched: directed scenarios plus randomized rounds
// checked against a channel-level round-robin model.
module tb_dma_sched;

    logic        PHI2 = 1'b0;
    logic        rst = 1'b1;
    logic        reg_we = 1'b0;
    logic [5:0]  reg_addr = 6'd0;
    logic [7:0]  reg_wdata = 8'd0;
    logic        eng_done = 1'b0;
    logic [15:0] eng_sadd, eng_sinc, eng_dadd, eng_dinc, eng_count;
    logic        eng_start, irq;
    logic [1:0]  active_ch;
    logic [3:0]  ch_pend, ch_done;

    dma_sched #(.NCH(4)) dut (
        .PHI2(PHI2), .rst(rst), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .eng_sadd(eng_sadd), .eng_sinc(eng_sinc), .eng_dadd(eng_dadd), .eng_dinc(eng_dinc),
        .eng_count(eng_count), .eng_start(eng_start), .eng_done(eng_done),
        .active_ch(active_ch), .ch_pend(ch_pend), .ch_done(ch_done), .irq(irq)
    );

    always #5 PHI2 = ~PHI2;

    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;

    // model: per-channel parameters (sadd,sinc,dadd,dinc,count) and flags
    logic [15:0] m_par [4][5];
    logic [3:0]  m_pend, m_done, m_irqen;
    int          m_last;
    int          m_act;

    always @(negedge PHI2) if (eng_start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge PHI2);
        #1;
    endtask

    task automatic model_clear();
        m_pend = 4'd0; m_done = 4'd0; m_irqen = 4'd0; m_last = 3; m_act = 0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 5; k++) m_par[c][k] = 16'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        model_clear();
    endtask

    task automatic wr(input int ch, input int idx, input logic [7:0] d);
        logic [1:0] c2;
        logic [3:0] i4;
        c2 = ch[1:0]; i4 = idx[3:0];
        reg_we = 1'b1; reg_addr = {c2, i4}; reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rand_params(input int ch, input bit zero);
        for (int k = 0; k < 4; k++) m_par[ch][k] = 16'($urandom);
        m_par[ch][4] = zero ? 16'd0 : 16'($urandom_range(1, 65535));
    endtask

    task automatic write_params(input int ch);
        for (int k = 0; k < 5; k++) begin
            wr(ch, 2 * k, m_par[ch][k][7:0]);
            wr(ch, 2 * k + 1, m_par[ch][k][15:8]);
        end
    endtask

    task automatic start(input int ch, input bit ie);
        wr(ch, 10, {6'd0, ie, 1'b1});
        m_pend[ch] = 1'b1; m_irqen[ch] = ie;
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (m_last + k) % 4;
            if (m_pend[c]) return c;
        end
        return -1;
    endfunction

    // wait for a start pulse and compare the grant against the round-robin model
    task automatic wait_start(output int got);
        bit seen;
        int exp;
        logic [79:0] exp_par, act_par;
        seen = 1'b0; got = -1;
        for (int i = 0; i < 40; i++) begin
            if (eng_start === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL eng_start_timeout: got no pulse, required one within 40 cycles");
            return;
        end
        exp = rr_pick();
        got = int'(active_ch);
        n_checks++;
        if (exp < 0 || active_ch !== exp[1:0]) begin
            n_fail++;
            $display("FAIL grant_channel: got %0d expected %0d", active_ch, exp);
        end
        if (exp >= 0) m_act = exp;
        exp_par = {m_par[m_act][0], m_par[m_act][1], m_par[m_act][2], m_par[m_act][3], m_par[m_act][4]};
        act_par = {eng_sadd, eng_sinc, eng_dadd, eng_dinc, eng_count};
        n_checks++;
        if (act_par !== exp_par) begin
            n_fail++;
            $display("FAIL eng_params: got %h expected %h", act_par, exp_par);
        end
        tick();
        n_checks++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL eng_start_width: got %b expected 0", eng_start);
        end
    endtask

    // complete the running transfer; collide also clears done on the same edge
    task automatic finish(input bit collide);
        logic [1:0] a2;
        repeat ($urandom_range(0, 3)) tick();
        a2 = m_act[1:0];
        eng_done = 1'b1;
        if (collide) begin
            reg_we = 1'b1; reg_addr = {a2, 4'd11}; reg_wdata = 8'h00;
        end
        tick();
        eng_done = 1'b0; reg_we = 1'b0;
        m_pend[m_act] = 1'b0; m_done[m_act] = 1'b1; m_last = m_act;
        n_checks++;
        if (ch_pend !== m_pend) begin
            n_fail++;
            $display("FAIL pend_after_done: got %b expected %b", ch_pend, m_pend);
        end
        n_checks++;
        if (ch_done !== m_done) begin
            n_fail++;
            $display("FAIL done_after_done: got %b expected %b", ch_done, m_done);
        end
        n_checks++;
        if (irq !== (|(m_done & m_irqen))) begin
            n_fail++;
            $display("FAIL irq_after_done: got %b expected %b", irq, |(m_done & m_irqen));
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ch_pend, ch_done, irq, eng_start, active_ch} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_flags: got %h expected 0", {ch_pend, ch_done, irq, eng_start, active_ch});
        end
        n_checks++;
        if ({eng_sadd, eng_sinc, eng_dadd, eng_dinc, eng_count} !== 80'd0) begin
            n_fail++;
            $display("FAIL reset_eng: got %h expected 0", {eng_sadd, eng_sinc, eng_dadd, eng_dinc, eng_count});
        end
    endtask

    task automatic test_single();
        int g, s0;
        do_reset();
        m_par[0][0] = 16'h1000; m_par[0][1] = 16'h0001; m_par[0][2] = 16'h2000;
        m_par[0][3] = 16'h0001; m_par[0][4] = 16'h0010;
        write_params(0);
        s0 = start_cnt;
        start(0, 1'b0);
        tick();
        n_checks++;
        if (eng_start !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: got %b expected 0", eng_start);
        end
        tick();
        n_checks++;
        if (eng_start !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_n2: got %b expected 1", eng_start);
        end
        wait_start(g);
        finish(1'b0);
        n_checks++;
        if ({ch_done, ch_pend} !== 8'b0001_0000) begin
            n_fail++;
            $display("FAIL single_flags: got %b expected 00010000", {ch_done, ch_pend});
        end
        n_checks++;
        if (start_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL single_pulses: got %0d expected 1", start_cnt - s0);
        end
    endtask

    task automatic test_round_robin();
        int seq [6];
        int exp_seq [6] = '{0, 1, 2, 3, 0, 2};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            rand_params(c, 1'b0);
            write_params(c);
        end
        start(0, 1'($urandom_range(0, 1)));
        wait_start(seq[0]);
        for (int c = 1; c < 4; c++) start(c, 1'($urandom_range(0, 1)));
        finish(1'b0);
        wait_start(seq[1]); finish(1'b0);
        wait_start(seq[2]); finish(1'b0);
        wait_start(seq[3]);
        start(2, 1'b0);
        start(0, 1'b1);
        finish(1'b0);
        wait_start(seq[4]); finish(1'b0);
        wait_start(seq[5]); finish(1'b0);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (seq[i] !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_zero_count();
        int s0;
        do_reset();
        rand_params(1, 1'b1);
        write_params(1);
        s0 = start_cnt;
        start(1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ch_done[1] === 1'b1) break;
        end
        m_pend[1] = 1'b0; m_done[1] = 1'b1; m_last = 1;
        n_checks++;
        if ({ch_done, ch_pend, irq} !== {m_done, m_pend, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_done: got %b expected %b", {ch_done, ch_pend, irq}, {m_done, m_pend, 1'b1});
        end
        repeat (4) tick();
        n_checks++;
        if (start_cnt !== s0) begin
            n_fail++;
            $display("FAIL zero_no_start: got %0d pulses expected 0", start_cnt - s0);
        end
        wr(1, 11, 8'h5A);
        m_done[1] = 1'b0;
        n_checks++;
        if ({irq, ch_done} !== {1'b0, m_done}) begin
            n_fail++;
            $display("FAIL zero_irq_clear: got %b expected %b", {irq, ch_done}, {1'b0, m_done});
        end
    endtask

    task automatic test_cancel();
        int g, s0;
        do_reset();
        rand_params(0, 1'b0); write_params(0);
        rand_params(2, 1'b0); write_params(2);
        start(0, 1'b0);
        wait_start(g);
        start(2, 1'b1);
        n_checks++;
        if (ch_pend !== 4'b0101) begin
            n_fail++;
            $display("FAIL cancel_prepend: got %b expected 0101", ch_pend);
        end
        wr(2, 10, 8'h04);
        m_pend[2] = 1'b0;
        n_checks++;
        if ({ch_pend, ch_done[2]} !== {m_pend, 1'b0}) begin
            n_fail++;
            $display("FAIL cancel_ch2: got %b expected %b", {ch_pend, ch_done[2]}, {m_pend, 1'b0});
        end
        wr(0, 10, 8'h04);
        n_checks++;
        if (ch_pend[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL cancel_granted: got %b expected 1", ch_pend[0]);
        end
        wr(0, 0, 8'hAB);
        finish(1'b1);
        s0 = start_cnt;
        repeat (10) tick();
        n_checks++;
        if (start_cnt !== s0) begin
            n_fail++;
            $display("FAIL cancel_no_grant: got %0d pulses expected 0", start_cnt - s0);
        end
        start(0, 1'b1);
        wait_start(g);
        finish(1'b0);
    endtask

    task automatic test_rst_run();
        int g, s0;
        do_reset();
        rand_params(3, 1'b0); write_params(3);
        start(3, 1'b1);
        wait_start(g);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        model_clear();
        n_checks++;
        if ({ch_pend, ch_done, irq, eng_start, active_ch, eng_count, eng_sadd} !== 44'd0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got %h expected 0",
                     {ch_pend, ch_done, irq, eng_start, active_ch, eng_count, eng_sadd});
        end
        s0 = start_cnt;
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        repeat (8) tick();
        n_checks++;
        if ({ch_done, ch_pend} !== 8'd0 || start_cnt !== s0) begin
            n_fail++;
            $display("FAIL rst_late_done: got flags %b pulses %0d expected 0", {ch_done, ch_pend}, start_cnt - s0);
        end
    endtask

    task automatic test_random();
        int g, mask, j, t;
        int ord[$];
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 4; c++) wr(c, 11, 8'h00);
            m_done = 4'd0;
            mask = $urandom_range(1, 15);
            ord.delete();
            for (int c = 0; c < 4; c++) if (mask[c]) ord.push_back(c);
            for (int i = ord.size() - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                t = ord[i]; ord[i] = ord[j]; ord[j] = t;
            end
            foreach (ord[i]) begin
                rand_params(ord[i], 1'b0);
                write_params(ord[i]);
            end
            start(ord[0], 1'($urandom_range(0, 1)));
            wait_start(g);
            for (int i = 1; i < ord.size(); i++) start(ord[i], 1'($urandom_range(0, 1)));
            finish(1'b0);
            for (int i = 1; i < ord.size(); i++) begin
                wait_start(g);
                finish(1'b0);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single();
        test_round_robin();
        test_zero_count();
        test_cancel();
        test_rst_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
